// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: two-port ownership arbiter in front of a single sdspihost.
//
// Sequences card (re)initialisation (spi_rst pulse, then wait for the host to go
// idle), then hands the SPI host to one requester at a time using a round-robin
// pointer. While a port owns the host its command strobes and block address are
// passed straight through; the other port sees busy. A host error parks the
// arbiter in an error state until clr_err_i restarts initialisation.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   req_i[1:0]                   ownership requests ([0] raw reader, [1] eluks)
//   r_block_i, r_multi_block_i,
//   r_byte_i [1:0]               per-port command strobes
//   block_addr0_i, block_addr1_i per-port block address
//   clr_err_i                    clears the error state
//   spi_busy, spi_err            status from sdspihost
//   gnt_o[1:0]                   one-hot grant
//   busy_o[1:0]                  busy as seen by each requester
//   spi_rst                      sdspihost reset (active-high)
//   spi_r_block, spi_r_multi_block, spi_r_byte, spi_block_addr  to sdspihost
//   ready_o, error_o             serviceable / sticky error status
module sd_spi_arbiter #(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  r_block_i,
  input  logic [1:0]  r_multi_block_i,
  input  logic [1:0]  r_byte_i,
  input  logic [31:0] block_addr0_i,
  input  logic [31:0] block_addr1_i,
  input  logic        clr_err_i,
  input  logic        spi_busy,
  input  logic        spi_err,
  output logic [1:0]  gnt_o,
  output logic [1:0]  busy_o,
  output logic        spi_rst,
  output logic        spi_r_block,
  output logic        spi_r_multi_block,
  output logic        spi_r_byte,
  output logic [31:0] spi_block_addr,
  output logic        ready_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    S_RST,
    S_INIT,
    S_IDLE,
    S_OWN,
    S_DRAIN,
    S_ERR
  } state_e;

  localparam logic [7:0] RstLast = 8'(RST_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  // Last port served; the other port has priority on a simultaneous request.
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic       own;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RST;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;  // favour port 0 after reset
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    unique case (state_q)
      S_RST: begin
        if (cnt_q == RstLast) begin
          state_d = S_INIT;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_INIT: begin
        // cnt_q flags that the entry clock has passed, so the first eligible
        // spi_busy sample is two clocks after entry.
        if (spi_err) begin
          state_d = S_ERR;
        end else if (cnt_q != 8'd0 && !spi_busy) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = 8'd1;
        end
      end
      S_IDLE: begin
        if (spi_err) begin
          state_d = S_ERR;
        end else if (req_i != 2'b00) begin
          state_d = S_OWN;
          owner_d = (req_i == 2'b11) ? ~last_q : req_i[1];
        end
      end
      S_OWN: begin
        if (spi_err) begin
          state_d = S_ERR;
        end else if (!req_i[owner_q]) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (spi_err) begin
          state_d = S_ERR;
        end else if (!spi_busy) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end
      end
      S_ERR: begin
        if (clr_err_i) begin
          state_d = S_RST;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign own = (state_q == S_OWN);

  always_comb begin
    gnt_o             = 2'b00;
    busy_o            = 2'b11;
    spi_r_block       = 1'b0;
    spi_r_multi_block = 1'b0;
    spi_r_byte        = 1'b0;
    spi_block_addr    = 32'd0;
    if (own) begin
      gnt_o[owner_q]    = 1'b1;
      busy_o[owner_q]   = spi_busy;
      spi_r_block       = r_block_i[owner_q];
      spi_r_multi_block = r_multi_block_i[owner_q];
      spi_r_byte        = r_byte_i[owner_q];
      spi_block_addr    = owner_q ? block_addr1_i : block_addr0_i;
    end
  end

  assign spi_rst = (state_q == S_RST);
  assign ready_o = (state_q == S_IDLE) || own || (state_q == S_DRAIN);
  assign error_o = (state_q == S_ERR);

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Self-checking bench for sd_spi_arbiter: directed scenarios followed by a
// randomized request/busy/strobe phase checked against a transaction-level model.
module tb_sd_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  r_block_i, r_multi_block_i, r_byte_i;
  logic [31:0] block_addr0_i, block_addr1_i;
  logic        clr_err_i, spi_busy, spi_err;
  logic [1:0]  gnt_o, busy_o;
  logic        spi_rst, spi_r_block, spi_r_multi_block, spi_r_byte;
  logic [31:0] spi_block_addr;
  logic        ready_o, error_o;

  int n_checks = 0;
  int n_err    = 0;

  sd_spi_arbiter #(.RST_CYCLES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_i             (req_i),
    .r_block_i         (r_block_i),
    .r_multi_block_i   (r_multi_block_i),
    .r_byte_i          (r_byte_i),
    .block_addr0_i     (block_addr0_i),
    .block_addr1_i     (block_addr1_i),
    .clr_err_i         (clr_err_i),
    .spi_busy          (spi_busy),
    .spi_err           (spi_err),
    .gnt_o             (gnt_o),
    .busy_o            (busy_o),
    .spi_rst           (spi_rst),
    .spi_r_block       (spi_r_block),
    .spi_r_multi_block (spi_r_multi_block),
    .spi_r_byte        (spi_r_byte),
    .spi_block_addr    (spi_block_addr),
    .ready_o           (ready_o),
    .error_o           (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: who holds the host, whether it is being released,
  // and who was served last.
  int   m_owner;
  bit   m_drain;
  bit   m_last;
  int   ones;
  int   waited;
  logic [1:0]  e_gnt, e_busy;
  logic        e_rb, e_rm, e_ry;
  logic [31:0] e_addr;

  initial begin
    rst = 1'b0;
    req_i = 2'b00; r_block_i = 2'b00; r_multi_block_i = 2'b00; r_byte_i = 2'b00;
    block_addr0_i = 32'd0; block_addr1_i = 32'd0;
    clr_err_i = 1'b0; spi_busy = 1'b1; spi_err = 1'b0;

    // Reset state
    #2;
    chk("rst_spi_rst", 32'(spi_rst), 32'd1);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd3);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_addr", spi_block_addr, 32'd0);

    // Init: spi_rst high exactly 16 clocks, ready one clock after busy falls
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    ones = 0;
    for (int i = 0; i < 50; i++) begin
      if (spi_rst) ones++;
      @(negedge clk);
    end
    chk("init_rst_len", 32'(ones), 32'd16);
    chk("init_not_ready", 32'(ready_o), 32'd0);
    spi_busy = 1'b0;
    @(negedge clk);
    chk("init_ready", 32'(ready_o), 32'd1);

    // Contention
    req_i = 2'b11;
    @(negedge clk);
    chk("cont_gnt0", 32'(gnt_o), 32'h1);
    req_i = 2'b10;
    @(negedge clk);
    chk("cont_drop", 32'(gnt_o), 32'h0);
    @(negedge clk);
    chk("cont_idle", 32'(gnt_o), 32'h0);
    @(negedge clk);
    chk("cont_gnt1", 32'(gnt_o), 32'h2);

    // Passthrough with port 1 as owner; port 0 strobes must be ignored
    block_addr1_i = 32'h2B; block_addr0_i = 32'h55;
    r_block_i = 2'b10; r_multi_block_i = 2'b01; r_byte_i = 2'b01;
    spi_busy = 1'b1;
    #1;
    chk("pass_addr", spi_block_addr, 32'h2B);
    chk("pass_rblock", 32'(spi_r_block), 32'd1);
    chk("pass_rmulti", 32'(spi_r_multi_block), 32'd0);
    chk("pass_rbyte", 32'(spi_r_byte), 32'd0);
    chk("pass_busy_busy", 32'(busy_o), 32'h3);
    spi_busy = 1'b0;
    #1;
    chk("pass_busy_idle", 32'(busy_o), 32'h1);
    r_block_i = 2'b00; r_multi_block_i = 2'b00; r_byte_i = 2'b00;

    // Drain: owner drops request while host still busy
    @(negedge clk);
    spi_busy = 1'b1;
    req_i = 2'b01;
    @(negedge clk);
    chk("drain_gnt_drop", 32'(gnt_o), 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("drain_hold", 32'(gnt_o), 32'h0);
    end
    spi_busy = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(gnt_o), 32'h0);
    @(negedge clk);
    chk("drain_regrant", 32'(gnt_o), 32'h1);

    // Error in S_OWN, sticky until clr_err_i, then re-init
    r_block_i = 2'b01;
    spi_err = 1'b1;
    @(negedge clk);
    chk("err_flag", 32'(error_o), 32'd1);
    chk("err_gnt", 32'(gnt_o), 32'd0);
    chk("err_strobe", 32'(spi_r_block), 32'd0);
    chk("err_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    spi_err = 1'b0;
    chk("err_sticky", 32'(error_o), 32'd1);
    clr_err_i = 1'b1; req_i = 2'b00; r_block_i = 2'b00;
    @(negedge clk);
    clr_err_i = 1'b0;
    chk("clr_error", 32'(error_o), 32'd0);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      if (spi_rst) ones++;
      @(negedge clk);
    end
    chk("reinit_rst_len", 32'(ones), 32'd16);
    chk("reinit_ready", 32'(ready_o), 32'd1);

    // Stray clr_err_i outside S_ERR is ignored
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
    chk("clr_ignored", 32'(spi_rst), 32'd0);

    // Async reset mid-ownership
    req_i = 2'b10; r_block_i = 2'b10; block_addr1_i = 32'h1234;
    @(negedge clk);
    chk("ar_gnt", 32'(gnt_o), 32'h2);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_gnt_drop", 32'(gnt_o), 32'h0);
    chk("ar_spi_rst", 32'(spi_rst), 32'd1);
    chk("ar_strobe", 32'(spi_r_block), 32'd0);
    chk("ar_addr", spi_block_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    req_i = 2'b00; r_block_i = 2'b00; block_addr1_i = 32'd0;
    spi_busy = 1'b0;

    // Randomized phase
    waited = 0;
    while (!ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("rand_ready", 32'(ready_o), 32'd1);
    m_owner = -1; m_drain = 1'b0; m_last = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 3) == 0) req_i[b] = ~req_i[b];
      spi_busy        = ($urandom_range(0, 2) == 0);
      r_block_i       = 2'($urandom);
      r_multi_block_i = 2'($urandom);
      r_byte_i        = 2'($urandom);
      block_addr0_i   = $urandom;
      block_addr1_i   = $urandom;
      #1;
      e_gnt = 2'b00; e_busy = 2'b11; e_rb = 1'b0; e_rm = 1'b0; e_ry = 1'b0; e_addr = 32'd0;
      if (m_owner >= 0 && !m_drain) begin
        e_gnt[m_owner]  = 1'b1;
        e_busy[m_owner] = spi_busy;
        e_rb   = r_block_i[m_owner];
        e_rm   = r_multi_block_i[m_owner];
        e_ry   = r_byte_i[m_owner];
        e_addr = (m_owner == 1) ? block_addr1_i : block_addr0_i;
      end
      chk("rand_gnt", 32'(gnt_o), 32'(e_gnt));
      chk("rand_busy", 32'(busy_o), 32'(e_busy));
      chk("rand_strobes", {29'd0, spi_r_block, spi_r_multi_block, spi_r_byte},
          {29'd0, e_rb, e_rm, e_ry});
      chk("rand_addr", spi_block_addr, e_addr);
      chk("rand_ready_hold", 32'(ready_o), 32'd1);
      @(posedge clk);
      if (m_owner < 0) begin
        if (req_i == 2'b11) m_owner = m_last ? 0 : 1;
        else if (req_i == 2'b01) m_owner = 0;
        else if (req_i == 2'b10) m_owner = 1;
      end else if (!m_drain) begin
        if (!req_i[m_owner]) m_drain = 1'b1;
      end else if (!spi_busy) begin
        m_last  = (m_owner == 1);
        m_owner = -1;
        m_drain = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global timeout guard
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
